// File: rtl/alu_mc_if.sv
// Request/result handshake bundle for the multi-cycle ALU.
// The master issues operations and consumes registered results.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] InA;
  logic [WIDTH-1:0] InB;
  logic             Cin;
  logic [3:0]       Oper;
  logic             invA;
  logic             invB;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             Zero;
  logic             Ofl;
  logic             busy;

  modport master (
    output in_valid, InA, InB, Cin, Oper,
    output invA, invB, sign, out_ready,
    input  in_ready, out_valid, Out,
    input  Zero, Ofl, busy
  );

  modport slave (
    input  in_valid, InA, InB, Cin, Oper,
    input  invA, invB, sign, out_ready,
    output in_ready, out_valid, Out,
    output Zero, Ofl, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle ops plus iterative
// unsigned multiply / divide / remainder behind valid/ready.
module alu_mc #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int CNT_W   = 5
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int H = WIDTH / 2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d, b_q;
  logic             out_valid_q, zero_q, ofl_q;
  logic [WIDTH-1:0] out_q;

  logic [WIDTH-1:0]   a, b;
  logic [SHAMT_W-1:0] sh;
  logic               in_ready, accept;
  logic               iter_op, done, load;
  logic [2*WIDTH-1:0] rot2;
  logic [WIDTH:0]     sum, madd, dsh;
  logic [WIDTH-1:0]   rev, s_res, i_res, res;
  logic               s_ofl, i_ofl, res_ofl;

  assign a  = bus.invA ? ~bus.InA : bus.InA;
  assign b  = bus.invB ? ~bus.InB : bus.InB;
  assign sh = b[SHAMT_W-1:0];

  assign in_ready = (state_q == IDLE) &&
                    (!out_valid_q || bus.out_ready) &&
                    !rst;
  assign iter_op = (&bus.Oper[3:2]) && (|bus.Oper[1:0]);
  assign accept  = bus.in_valid && in_ready;
  assign done    = (state_q == BUSY) &&
                   (cnt_q == CNT_W'(1));
  assign load    = (accept && !iter_op) || done;

  always_comb begin
    rot2  = {a, a} << sh;
    sum   = {1'b0, a} + {1'b0, b} +
            (WIDTH+1)'(bus.Cin);
    for (int i = 0; i < WIDTH; i++)
      rev[i] = a[WIDTH-1-i];
    s_res = '0;
    s_ofl = 1'b0;
    case (bus.Oper)
      4'b0000: s_res = rot2[2*WIDTH-1:WIDTH];
      4'b0001: s_res = a << sh;
      4'b0010: s_res = $signed(a) >>> sh;
      4'b0011: s_res = a >> sh;
      4'b0100: begin
        s_res = sum[WIDTH-1:0];
        s_ofl = bus.sign ?
          ((a[WIDTH-1] == b[WIDTH-1]) &&
           (sum[WIDTH-1] != a[WIDTH-1])) :
          sum[WIDTH];
      end
      4'b0101: s_res = a & b;
      4'b0110: s_res = {a[H-1:0], {H{1'b0}}} | b;
      4'b0111: s_res = a ^ b;
      4'b1000: s_res = rev;
      4'b1001: s_res = WIDTH'(a == b);
      4'b1010: s_res = WIDTH'($signed(a) < $signed(b));
      4'b1011: s_res = WIDTH'($signed(a) <= $signed(b));
      4'b1100: s_res = WIDTH'(sum[WIDTH]);
      default: ;
    endcase
  end

  // hi:lo is the product (shift-add) or remainder:quotient
  always_comb begin
    madd = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
    dsh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    if (op_q == 2'b01) begin
      hi_d = {1'b0, madd[WIDTH:1]};
      lo_d = {madd[0], lo_q[WIDTH-1:1]};
    end else if (dsh >= {1'b0, b_q}) begin
      hi_d = dsh - {1'b0, b_q};
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = dsh;
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
    i_res = lo_d;
    i_ofl = (b_q == '0);
    if (op_q == 2'b01)
      i_ofl = |hi_d[WIDTH-1:0];
    else if (op_q == 2'b11)
      i_res = hi_d[WIDTH-1:0];
  end

  assign res     = done ? i_res : s_res;
  assign res_ofl = done ? i_ofl : s_ofl;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && iter_op) state_d = BUSY;
      BUSY: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else if (accept && iter_op) begin
      cnt_q <= CNT_W'(WIDTH);
      op_q  <= bus.Oper[1:0];
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - 1'b1;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      ofl_q       <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_q       <= res;
      zero_q      <= (res == '0);
      ofl_q       <= res_ofl;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.Out       = out_q;
  assign bus.Zero      = zero_q;
  assign bus.Ofl       = ofl_q;
  assign bus.busy      = (state_q == BUSY);
endmodule
